// File: rtl/uart_pkg.sv
// Shared state encoding and timing helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Cycles the FSM waits for the FIFO ready pulse, counting the rd_en cycle.
  localparam int RD_WAIT_WINDOW = 3;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read handshake between the byte FIFO (slave) and the UART drain (master).
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_rd_data;
  logic                  i_fifo_ready_pulse;
  logic                  o_fifo_rd_en;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_rd_data,
    input  i_fifo_ready_pulse,
    output o_fifo_rd_en
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_rd_data,
    output i_fifo_ready_pulse,
    input  o_fifo_rd_en
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; ticks on the last clock of each bit period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (i_clear || (cnt_reg == CNT_LAST)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_bit_tick = !i_clear && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from the byte FIFO and serialises them LSB first as 8N1/8N2 UART frames.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_enable,
  uart_tx_fifo_drain_if.master        fifo,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic                        o_done_pulse
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [1:0]       WAIT_LAST = 2'(RD_WAIT_WINDOW - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if ((CLKS_PER_BIT < 2) || ((STOP_BITS != 1) && (STOP_BITS != 2))) begin : g_param_check
    $error("uart_tx_fifo_drain: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
  end

  tx_state_t             state_reg, state_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  rd_en_reg, rd_en_next;
  logic                  done_reg, done_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
  logic [1:0]            wait_cnt_reg, wait_cnt_next;
  logic                  stop_cnt_reg, stop_cnt_next;
  logic                  baud_clear;
  logic                  bit_tick;

  // Bit periods are aligned to the first start-bit cycle by holding the counter clear until then.
  assign baud_clear = (state_reg == IDLE) || (state_reg == WAIT_DATA);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (baud_clear),
    .o_bit_tick (bit_tick)
  );

  always_comb begin
    state_next    = state_reg;
    tx_next       = tx_reg;
    busy_next     = busy_reg;
    rd_en_next    = 1'b0;
    done_next     = 1'b0;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    wait_cnt_next = wait_cnt_reg;
    stop_cnt_next = stop_cnt_reg;

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (i_enable && !fifo.i_fifo_empty) begin
          rd_en_next    = 1'b1;
          busy_next     = 1'b1;
          wait_cnt_next = '0;
          state_next    = WAIT_DATA;
        end
      end

      // Enable is not consulted here: an issued read is always honoured.
      WAIT_DATA: begin
        if (fifo.i_fifo_ready_pulse) begin
          shift_next = fifo.i_fifo_rd_data;
          tx_next    = 1'b0;
          state_next = START;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 2'd1;
        end
      end

      START: begin
        if (bit_tick) begin
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (bit_tick) begin
          if (bit_idx_reg == IDX_LAST) begin
            tx_next       = 1'b1;
            stop_cnt_next = 1'b0;
            state_next    = STOP;
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end

      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      rd_en_reg    <= 1'b0;
      done_reg     <= 1'b0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      wait_cnt_reg <= '0;
      stop_cnt_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      rd_en_reg    <= rd_en_next;
      done_reg     <= done_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      wait_cnt_reg <= wait_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
    end
  end

  assign o_tx              = tx_reg;
  assign o_busy            = busy_reg;
  assign o_done_pulse      = done_reg;
  assign fifo.o_fifo_rd_en = rd_en_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: FIFO responder model, frame monitor and scoreboard.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 10;

  logic clk;
  logic rst_n;
  logic en0, en1;
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;

  int   checks;
  int   errors;
  int   cyc;
  int   rd_cnt0, rd_cnt1;
  int   rd_last0, rd_prev0;
  int   frames [2];
  int   stray  [2];
  bit   stale0;
  bit   gap_check;

  logic [7:0] fifo0 [$];
  logic [7:0] fifo1 [$];
  logic [7:0] exp0  [$];
  logic [7:0] exp1  [$];

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus1 ();

  uart_tx_fifo_drain #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_WIDTH (8),
    .STOP_BITS  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (en0),
    .fifo         (bus0),
    .o_tx         (tx0),
    .o_busy       (busy0),
    .o_done_pulse (done0)
  );

  uart_tx_fifo_drain #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_WIDTH (8),
    .STOP_BITS  (2)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (en1),
    .fifo         (bus1),
    .o_tx         (tx1),
    .o_busy       (busy1),
    .o_done_pulse (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic get_tx(input int idx);
    return (idx == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_busy(input int idx);
    return (idx == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_done(input int idx);
    return (idx == 0) ? done0 : done1;
  endfunction

  function automatic int exp_size(input int idx);
    return (idx == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [7:0] exp_pop(input int idx);
    logic [7:0] v;
    v = 8'h00;
    if (idx == 0) begin
      if (exp0.size() > 0) v = exp0.pop_front();
    end else begin
      if (exp1.size() > 0) v = exp1.pop_front();
    end
    return v;
  endfunction

  // Ideal line level at cycle c of a frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int c);
    if (c < CPB) return 1'b0;
    if (c < 9 * CPB) return b[c / CPB - 1];
    return 1'b1;
  endfunction

  // Responds to rd_en with a ready pulse in the second window cycle; stale0 withholds it.
  initial begin
    bit pend0;
    bit pend1;
    pend0 = 1'b0;
    pend1 = 1'b0;
    bus0.i_fifo_ready_pulse = 1'b0;
    bus0.i_fifo_rd_data     = 8'h00;
    bus0.i_fifo_empty       = 1'b1;
    bus1.i_fifo_ready_pulse = 1'b0;
    bus1.i_fifo_rd_data     = 8'h00;
    bus1.i_fifo_empty       = 1'b1;
    forever begin
      @(negedge clk);
      bus0.i_fifo_ready_pulse = 1'b0;
      if (pend0 && (fifo0.size() > 0)) begin
        bus0.i_fifo_rd_data     = fifo0.pop_front();
        bus0.i_fifo_ready_pulse = 1'b1;
      end
      pend0 = 1'b0;
      if (bus0.o_fifo_rd_en === 1'b1) begin
        rd_cnt0++;
        rd_prev0 = rd_last0;
        rd_last0 = cyc;
        pend0    = !stale0;
      end
      bus0.i_fifo_empty = stale0 ? 1'b0 : (fifo0.size() == 0);

      bus1.i_fifo_ready_pulse = 1'b0;
      if (pend1 && (fifo1.size() > 0)) begin
        bus1.i_fifo_rd_data     = fifo1.pop_front();
        bus1.i_fifo_ready_pulse = 1'b1;
      end
      pend1 = 1'b0;
      if (bus1.o_fifo_rd_en === 1'b1) begin
        rd_cnt1++;
        pend1 = 1'b1;
      end
      bus1.i_fifo_empty = (fifo1.size() == 0);
    end
  end

  task automatic monitor(input int idx, input int sb);
    int         flen;
    int         high_run;
    int         busy_low;
    int         wave_err;
    bit         have_prev;
    bit         aborted;
    logic [7:0] eb;
    logic [7:0] rx;
    flen      = (9 + sb) * CPB;
    high_run  = 0;
    busy_low  = 0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        have_prev = 1'b0;
        continue;
      end
      if (get_tx(idx) !== 1'b0) begin
        high_run++;
        if (get_busy(idx) === 1'b0) busy_low++;
        if (get_done(idx) !== 1'b0) stray[idx]++;
        continue;
      end
      if ((idx == 0) && gap_check && have_prev) begin
        chk("gap_tx_high_cycles", high_run, 3);
        chk("gap_busy_low_cycles", busy_low, 1);
      end
      chk("frame_expected", int'(exp_size(idx) > 0), 1);
      eb       = exp_pop(idx);
      rx       = 8'h00;
      wave_err = 0;
      aborted  = 1'b0;
      for (int c = 0; c < flen; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (get_tx(idx) !== exp_level(eb, c)) wave_err++;
        if ((get_done(idx) !== 1'b0) || (get_busy(idx) !== 1'b1)) wave_err++;
        if ((c >= CPB) && (c < 9 * CPB) && ((c % CPB) == CPB / 2)) rx[c / CPB - 1] = get_tx(idx);
      end
      if (aborted) begin
        $display("dut%0d frame 0x%02h aborted by reset", idx, eb);
        have_prev = 1'b0;
        high_run  = 0;
        busy_low  = 0;
        continue;
      end
      @(negedge clk);
      chk("done_pulse_at_frame_end", int'(get_done(idx)), 1);
      chk("rx_byte", int'(rx), int'(eb));
      chk("frame_waveform_errors", wave_err, 0);
      frames[idx]++;
      $display("dut%0d frame rx=0x%02h exp=0x%02h len=%0d wave_err=%0d", idx, rx, eb, flen, wave_err);
      high_run  = (get_tx(idx) === 1'b1) ? 1 : 0;
      busy_low  = (get_busy(idx) === 1'b0) ? 1 : 0;
      have_prev = 1'b1;
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 2);

  task automatic push0(input logic [7:0] v);
    fifo0.push_back(v);
    exp0.push_back(v);
  endtask

  task automatic wait_frames(input int idx, input int target, input int budget);
    int n;
    n = 0;
    while ((frames[idx] < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk("frame_completed_in_time", int'(frames[idx] >= target), 1);
  endtask

  task automatic wait_start0(input int budget);
    int n;
    n = 0;
    while ((tx0 !== 1'b0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk("start_bit_seen", int'(tx0 === 1'b0), 1);
  endtask

  initial begin
    int base;
    int base1;
    int f;
    checks    = 0;
    errors    = 0;
    rd_cnt0   = 0;
    rd_cnt1   = 0;
    rd_last0  = 0;
    rd_prev0  = 0;
    frames[0] = 0;
    frames[1] = 0;
    stray[0]  = 0;
    stray[1]  = 0;
    stale0    = 1'b0;
    gap_check = 1'b0;
    rst_n     = 1'b0;
    en0       = 1'b0;
    en1       = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx0), 1);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_rd_en", int'(bus0.o_fifo_rd_en), 0);
    chk("reset_done", int'(done0), 0);
    rst_n = 1'b1;
    en0   = 1'b1;
    en1   = 1'b1;

    // Single word
    base = rd_cnt0;
    f    = frames[0];
    push0(8'hA5);
    wait_frames(0, f + 1, 300);
    repeat (5) @(negedge clk);
    chk("single_rd_en_count", rd_cnt0 - base, 1);

    // Back-to-back; the gap check arms once the first frame is under way
    base = rd_cnt0;
    f    = frames[0];
    push0(8'h00);
    push0(8'hFF);
    wait_start0(50);
    #1 gap_check = 1'b1;
    wait_frames(0, f + 2, 400);
    gap_check = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_rd_en_count", rd_cnt0 - base, 2);

    // Stale empty flag: no ready pulse ever arrives
    base   = rd_cnt0;
    stale0 = 1'b1;
    for (int i = 0; (i < 30) && (rd_cnt0 < base + 2); i++) @(negedge clk);
    chk("stale_rd_en_pulses", int'(rd_cnt0 - base >= 2), 1);
    chk("stale_retry_spacing", rd_last0 - rd_prev0, 4);
    chk("stale_tx_idle", int'(tx0), 1);
    stale0 = 1'b0;
    repeat (10) @(negedge clk);

    // Enable gating
    en0  = 1'b0;
    base = rd_cnt0;
    f    = frames[0];
    fifo0.push_back(8'h11);
    fifo0.push_back(8'h22);
    fifo0.push_back(8'h33);
    fifo0.push_back(8'h44);
    exp0.push_back(8'h11);
    repeat (50) @(negedge clk);
    chk("gated_no_rd_en", rd_cnt0 - base, 0);
    en0 = 1'b1;
    wait_start0(50);
    repeat (30) @(negedge clk);
    en0 = 1'b0;
    wait_frames(0, f + 1, 300);
    repeat (30) @(negedge clk);
    chk("gated_rd_en_count", rd_cnt0 - base, 1);
    chk("gated_fifo_left", fifo0.size(), 3);
    fifo0.delete();
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 3 (a zero bit of 0x47)
    en0 = 1'b1;
    push0(8'h47);
    wait_start0(50);
    repeat (45) @(negedge clk);
    chk("midrst_tx_before", int'(tx0), 0);
    chk("midrst_busy_before", int'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx0), 1);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_rd_en", int'(bus0.o_fifo_rd_en), 0);
    base = rd_cnt0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_reset_no_rd_en", rd_cnt0 - base, 0);

    // Two stop bits on the second instance
    base1 = rd_cnt1;
    f     = frames[1];
    fifo1.push_back(8'h3C);
    exp1.push_back(8'h3C);
    wait_frames(1, f + 1, 400);
    repeat (5) @(negedge clk);
    chk("stop2_rd_en_count", rd_cnt1 - base1, 1);

    chk("stray_done_dut0", stray[0], 0);
    chk("stray_done_dut1", stray[1], 0);
    chk("frames_total_dut0", frames[0], 4);
    chk("frames_total_dut1", frames[1], 1);
    chk("scoreboard_drained_dut0", exp0.size(), 0);
    chk("scoreboard_drained_dut1", exp1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
